// File: rtl/recv_check_module_if.sv
// Read-side packet stream into the receiver checker: framing pulses plus data word.
// The master drives the stream and the checker receives it through the slave modport.
interface recv_check_module_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  rd_sop;
   logic                  rd_eop;
   logic                  rd_vld;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (output rd_sop, rd_eop, rd_vld, rd_data);
   modport slave  (input  rd_sop, rd_eop, rd_vld, rd_data);
endinterface

// File: rtl/recv_check_module.sv
// Receiver-side packet checker: validates header, beat sequence and framing of each packet,
// and reports per-packet error flags plus running packet and error counts.
module recv_check_module #(
   parameter int rx_port        = 0,
   parameter int TIMEOUT        = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int WIDTH_SEL      = 4,
   parameter int WIDTH_PRIORITY = 3,
   parameter int WIDTH_LENGTH   = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   recv_check_module_if.slave        rd,
   output logic                      rx_idle,
   output logic                      pkt_done,
   output logic                      pkt_ok,
   output logic                      err_dest,
   output logic                      err_len,
   output logic                      err_data,
   output logic                      err_proto,
   output logic [WIDTH_SEL-1:0]      hdr_dest,
   output logic [WIDTH_PRIORITY-1:0] hdr_priority,
   output logic [WIDTH_LENGTH-1:0]   hdr_length,
   output logic [3:0]                src_port,
   output logic [15:0]               pkt_cnt,
   output logic [15:0]               err_cnt
);
   localparam int HW = WIDTH_SEL + WIDTH_PRIORITY + WIDTH_LENGTH;
   localparam int BW = WIDTH_LENGTH + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;

   state_t                    state_q, state_d;
   logic [BW-1:0]             beat_q, beat_d;
   logic [TW-1:0]             timer_q, timer_d;
   logic                      wk_dest_q, wk_dest_d, wk_len_q, wk_len_d;
   logic                      wk_data_q, wk_data_d, wk_proto_q, wk_proto_d;
   logic                      pkt_done_q, pkt_done_d, pkt_ok_q, pkt_ok_d;
   logic                      err_dest_q, err_dest_d, err_len_q, err_len_d;
   logic                      err_data_q, err_data_d, err_proto_q, err_proto_d;
   logic [WIDTH_SEL-1:0]      hdr_dest_q, hdr_dest_d;
   logic [WIDTH_PRIORITY-1:0] hdr_priority_q, hdr_priority_d;
   logic [WIDTH_LENGTH-1:0]   hdr_length_q, hdr_length_d;
   logic [3:0]                src_port_q, src_port_d;
   logic [15:0]               pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

   logic                      quiet, timeout_hit, beat_err, close, idle_err;
   logic                      cl_dest, cl_len, cl_data, cl_proto;
   logic [BW-1:0]             beat_inc;
   logic [HW-1:0]             hdr_word;

   assign quiet       = !rd.rd_sop && !rd.rd_eop && !rd.rd_vld;
   assign timeout_hit = (timer_q == TIMEOUT_LAST);
   assign beat_inc    = (beat_q == '1) ? beat_q : beat_q + BW'(1);
   assign hdr_word    = rd.rd_data[HW-1:0];
   // Beat 0 defines the source port, so only later beats are checked against it.
   assign beat_err    = (rd.rd_data[27:0] != 28'(beat_q)) ||
                        ((beat_q != '0) && (rd.rd_data[31:28] != src_port_q));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         beat_q         <= '0;
         timer_q        <= '0;
         wk_dest_q      <= 1'b0;
         wk_len_q       <= 1'b0;
         wk_data_q      <= 1'b0;
         wk_proto_q     <= 1'b0;
         pkt_done_q     <= 1'b0;
         pkt_ok_q       <= 1'b0;
         err_dest_q     <= 1'b0;
         err_len_q      <= 1'b0;
         err_data_q     <= 1'b0;
         err_proto_q    <= 1'b0;
         hdr_dest_q     <= '0;
         hdr_priority_q <= '0;
         hdr_length_q   <= '0;
         src_port_q     <= '0;
         pkt_cnt_q      <= '0;
         err_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         beat_q         <= beat_d;
         timer_q        <= timer_d;
         wk_dest_q      <= wk_dest_d;
         wk_len_q       <= wk_len_d;
         wk_data_q      <= wk_data_d;
         wk_proto_q     <= wk_proto_d;
         pkt_done_q     <= pkt_done_d;
         pkt_ok_q       <= pkt_ok_d;
         err_dest_q     <= err_dest_d;
         err_len_q      <= err_len_d;
         err_data_q     <= err_data_d;
         err_proto_q    <= err_proto_d;
         hdr_dest_q     <= hdr_dest_d;
         hdr_priority_q <= hdr_priority_d;
         hdr_length_q   <= hdr_length_d;
         src_port_q     <= src_port_d;
         pkt_cnt_q      <= pkt_cnt_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (rd.rd_sop && !rd.rd_eop) state_d = HEAD;
         HEAD, DATA: begin
            if (rd.rd_sop)                          state_d = HEAD;
            else if (rd.rd_eop)                     state_d = IDLE;
            else if (rd.rd_vld)                     state_d = DATA;
            else if (timeout_hit)                   state_d = IDLE;
         end
         default:                                   state_d = IDLE;
      endcase
   end

   // Closing flags are captured separately so a restart can clear the working flags same cycle.
   always_comb begin
      beat_d         = beat_q;
      timer_d        = timer_q;
      wk_dest_d      = wk_dest_q;
      wk_len_d       = wk_len_q;
      wk_data_d      = wk_data_q;
      wk_proto_d     = wk_proto_q;
      hdr_dest_d     = hdr_dest_q;
      hdr_priority_d = hdr_priority_q;
      hdr_length_d   = hdr_length_q;
      src_port_d     = src_port_q;
      close          = 1'b0;
      idle_err       = 1'b0;
      cl_dest        = wk_dest_q;
      cl_len         = wk_len_q;
      cl_data        = wk_data_q;
      cl_proto       = wk_proto_q;

      case (state_q)
         IDLE: begin
            if (rd.rd_eop || (rd.rd_vld && !rd.rd_sop)) begin
               idle_err = 1'b1;
            end else if (rd.rd_sop) begin
               {wk_dest_d, wk_len_d, wk_data_d, wk_proto_d} = '0;
               beat_d  = '0;
               timer_d = '0;
            end
         end
         HEAD, DATA: begin
            if (rd.rd_sop) begin
               close    = 1'b1;
               cl_proto = 1'b1;
               {wk_dest_d, wk_len_d, wk_data_d, wk_proto_d} = '0;
               beat_d   = '0;
               timer_d  = '0;
            end else if (state_q == HEAD && rd.rd_eop) begin
               close    = 1'b1;
               cl_proto = 1'b1;
               cl_len   = 1'b1;
            end else if (state_q == HEAD && rd.rd_vld) begin
               hdr_dest_d     = hdr_word[HW-1 -: WIDTH_SEL];
               hdr_priority_d = hdr_word[WIDTH_LENGTH+WIDTH_PRIORITY-1 -: WIDTH_PRIORITY];
               hdr_length_d   = hdr_word[WIDTH_LENGTH-1:0];
               wk_dest_d      = wk_dest_q | (hdr_word[HW-1 -: WIDTH_SEL] != WIDTH_SEL'(rx_port));
               wk_len_d       = wk_len_q | (hdr_word[WIDTH_LENGTH-1:0] == '0);
               timer_d        = '0;
            end else if (rd.rd_vld || rd.rd_eop) begin
               if (rd.rd_vld) begin
                  if (beat_q == '0) src_port_d = rd.rd_data[31:28];
                  wk_data_d = wk_data_q | beat_err;
                  beat_d    = beat_inc;
               end
               timer_d = '0;
               if (rd.rd_eop) begin
                  close   = 1'b1;
                  cl_data = wk_data_d;
                  cl_len  = wk_len_q | (beat_d != {1'b0, hdr_length_q});
               end
            end else if (timeout_hit) begin
               close    = 1'b1;
               cl_proto = 1'b1;
               cl_len   = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: ;
      endcase

      pkt_done_d  = close;
      pkt_ok_d    = close && !(cl_dest || cl_len || cl_data || cl_proto);
      err_dest_d  = close ? cl_dest  : err_dest_q;
      err_len_d   = close ? cl_len   : err_len_q;
      err_data_d  = close ? cl_data  : err_data_q;
      err_proto_d = close ? cl_proto : err_proto_q;
      pkt_cnt_d   = (close && pkt_cnt_q != 16'hFFFF) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
      err_cnt_d   = (((close && !pkt_ok_d) || idle_err) && err_cnt_q != 16'hFFFF)
                    ? err_cnt_q + 16'd1 : err_cnt_q;
   end

   assign rx_idle      = (state_q == IDLE);
   assign pkt_done     = pkt_done_q;
   assign pkt_ok       = pkt_ok_q;
   assign err_dest     = err_dest_q;
   assign err_len      = err_len_q;
   assign err_data     = err_data_q;
   assign err_proto    = err_proto_q;
   assign hdr_dest     = hdr_dest_q;
   assign hdr_priority = hdr_priority_q;
   assign hdr_length   = hdr_length_q;
   assign src_port     = src_port_q;
   assign pkt_cnt      = pkt_cnt_q;
   assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_recv_check_module.sv
// Directed self-checking bench for recv_check_module with rx_port=2 and 4/3/8 header fields.
module tb_recv_check_module;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_idle, pkt_done, pkt_ok;
   logic        err_dest, err_len, err_data, err_proto;
   logic [3:0]  hdr_dest;
   logic [2:0]  hdr_priority;
   logic [7:0]  hdr_length;
   logic [3:0]  src_port;
   logic [15:0] pkt_cnt, err_cnt;
   int          test_count = 0;
   int          fail_count = 0;

   recv_check_module_if #(.DATA_WIDTH(32)) rd_if ();

   recv_check_module #(
      .rx_port(2), .TIMEOUT(64), .DATA_WIDTH(32),
      .WIDTH_SEL(4), .WIDTH_PRIORITY(3), .WIDTH_LENGTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rd(rd_if.slave),
      .rx_idle(rx_idle), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
      .err_dest(err_dest), .err_len(err_len), .err_data(err_data), .err_proto(err_proto),
      .hdr_dest(hdr_dest), .hdr_priority(hdr_priority), .hdr_length(hdr_length),
      .src_port(src_port), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Drive one cycle of the stream and settle just after the rising edge.
   task automatic applyStimulus(input logic sop, input logic eop, input logic vld,
                                input logic [31:0] data);
      rd_if.rd_sop  = sop;
      rd_if.rd_eop  = eop;
      rd_if.rd_vld  = vld;
      rd_if.rd_data = data;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sendWords(input logic [3:0] src, input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b1, {src, 28'(k)});
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("reset_rx_idle", 32'(rx_idle), 32'd1);
      checkOutput("reset_pkt_done", 32'(pkt_done), 32'd0);
      checkOutput("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

      // Good packet: dest=2 prio=5 len=4.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("sop_leaves_idle", 32'(rx_idle), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1504);
      sendWords(4'h2, 4);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("good_done", 32'(pkt_done), 32'd1);
      checkOutput("good_ok", 32'(pkt_ok), 32'd1);
      checkOutput("good_src", 32'(src_port), 32'd2);
      checkOutput("good_hdr", {hdr_dest, 1'b0, hdr_priority, hdr_length}, 32'h0000_2504);
      checkOutput("good_cnts", {pkt_cnt, err_cnt}, {16'd1, 16'd0});
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("done_is_pulse", 32'(pkt_done), 32'd0);

      // Wrong destination: dest=3 len=2.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1802);
      sendWords(4'h2, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("dest_flags", {pkt_done, pkt_ok, err_dest, err_len, err_data, err_proto},
                  32'b10_1000);
      checkOutput("dest_cnts", {pkt_cnt, err_cnt}, {16'd2, 16'd1});

      // Corrupt word 1 and short by one beat: len=3, two words sent.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1003);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h2000_0000);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h2000_0005);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("data_flags", {pkt_done, pkt_ok, err_dest, err_len, err_data, err_proto},
                  32'b10_0110);
      checkOutput("data_cnts", {pkt_cnt, err_cnt}, {16'd3, 16'd2});

      // sop in DATA after one word restarts immediately into HEAD.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1504);
      sendWords(4'h2, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("resop_done", 32'(pkt_done), 32'd1);
      checkOutput("resop_proto", {pkt_ok, err_proto}, 32'b01);
      checkOutput("resop_in_head", 32'(rx_idle), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1504);
      sendWords(4'h3, 4);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("resop_second_ok", {pkt_done, pkt_ok, 2'b00, src_port}, 32'h0000_00C3);
      checkOutput("resop_cnts", {pkt_cnt, err_cnt}, {16'd5, 16'd3});

      // Last word arrives together with eop.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1002);
      sendWords(4'h2, 1);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h2000_0001);
      checkOutput("vld_eop_ok", {pkt_done, pkt_ok, err_len, err_data}, 32'b1100);
      checkOutput("vld_eop_cnt", 32'(pkt_cnt), 32'd6);

      // Stall inside a packet until the idle timer expires.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1504);
      for (int i = 0; i < 63; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_63_no_done", {pkt_done, rx_idle}, 32'b00);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_timeout", {pkt_done, pkt_ok, err_len, err_proto, rx_idle}, 32'b10111);
      checkOutput("stall_cnts", {pkt_cnt, err_cnt}, {16'd7, 16'd4});

      // Stray vld and eop while idle count as errors without pkt_done.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678);
      checkOutput("idle_vld", {pkt_done, rx_idle, err_cnt}, {14'd0, 2'b01, 16'd5});
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("idle_sop_eop", {pkt_done, rx_idle, err_cnt}, {14'd0, 2'b01, 16'd6});
      checkOutput("idle_pkt_cnt", 32'(pkt_cnt), 32'd7);

      // eop in HEAD, then a one-word packet starting on the very next cycle.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("head_eop", {pkt_done, pkt_ok, err_len, err_proto, rx_idle}, 32'b10111);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1001);
      sendWords(4'h2, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("b2b_ok", {pkt_done, pkt_ok}, 32'b11);
      checkOutput("b2b_cnts", {pkt_cnt, err_cnt}, {16'd9, 16'd7});

      // Reset mid-packet abandons silently.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1504);
      sendWords(4'h2, 1);
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b1;
      checkOutput("rst_flags", {pkt_done, pkt_ok, err_dest, err_len, err_data, err_proto, rx_idle},
                  32'b0000001);
      checkOutput("rst_regs", {hdr_dest, hdr_priority, hdr_length, src_port}, 32'd0);
      checkOutput("rst_cnts", {pkt_cnt, err_cnt}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1504);
      sendWords(4'h2, 4);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("post_rst_good", {pkt_done, pkt_ok, pkt_cnt}, {14'd0, 2'b11, 16'd1});

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end
endmodule
